// File: rtl/ign_pkg.sv
// ---------------------------------------------------------------------------
// ign_pkg
// Shared constants and the channel state encoding for the multi-channel
// ignition scheduler (ign_sched_multi / ign_sched_channel).
//   IGN_*            default widths and timing constants
//   ign_state_e      per-channel scheduler state (IDLE / WAIT / DWELL)
// ---------------------------------------------------------------------------
package ign_pkg;

  localparam int IGN_NCH          = 4;
  localparam int IGN_PHASE_W      = 16;
  localparam int IGN_CYCLE_QUANTA = 15360;  // quanta per 720 deg engine cycle
  localparam int IGN_PERIOD_W     = 32;
  localparam int IGN_FRAC_SHIFT   = 8;      // tooth_period is per 2^8 quanta
  localparam int IGN_MARGIN       = 20;     // slack added to the arm window
  localparam int IGN_LAT_COMP     = 6;      // clk cycles of output latency
  localparam int IGN_DWELL_W      = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DWELL = 2'd2
  } ign_state_e;

endpackage

// File: rtl/ign_sched_channel.sv
// ---------------------------------------------------------------------------
// ign_sched_channel
// One ignition channel: arm test, saturating delay computation, dwell
// start offset, and the IDLE -> WAIT -> DWELL -> IDLE event counter.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   trigger              tooth edge pulse (shared)
//   eng_phase            engine phase at trigger, quanta
//   next_tooth_width     quanta until next tooth
//   tooth_period         clk cycles per 2^FRAC_SHIFT quanta
//   spark_angle          this channel's spark angle, quanta
//   dwell_clks           this channel's dwell time, clk cycles
//   ch_enable            channel enable; low while armed aborts
//   coil_out             coil drive (registered)
//   spark_pulse          one-cycle pulse as coil falls (registered)
//   short_dwell          one-cycle pulse with spark when dwell was cut short
//   busy                 channel armed (registered)
// ---------------------------------------------------------------------------
module ign_sched_channel
  import ign_pkg::*;
#(
  parameter int PHASE_W      = IGN_PHASE_W,
  parameter int CYCLE_QUANTA = IGN_CYCLE_QUANTA,
  parameter int PERIOD_W     = IGN_PERIOD_W,
  parameter int FRAC_SHIFT   = IGN_FRAC_SHIFT,
  parameter int MARGIN       = IGN_MARGIN,
  parameter int LAT_COMP     = IGN_LAT_COMP,
  parameter int DWELL_W      = IGN_DWELL_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                trigger,
  input  logic [PHASE_W-1:0]  eng_phase,
  input  logic [PHASE_W-1:0]  next_tooth_width,
  input  logic [PERIOD_W-1:0] tooth_period,
  input  logic [PHASE_W-1:0]  spark_angle,
  input  logic [DWELL_W-1:0]  dwell_clks,
  input  logic                ch_enable,
  output logic                coil_out,
  output logic                spark_pulse,
  output logic                short_dwell,
  output logic                busy
);

  localparam int QW     = PHASE_W + 1;
  localparam int PROD_W = PERIOD_W + QW;
  localparam logic [PERIOD_W-1:0] CNT_ZERO = {PERIOD_W{1'b0}};
  localparam logic [PERIOD_W-1:0] CNT_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_W-1:0] CNT_MAX  = {PERIOD_W{1'b1}};

  // Combinational arm/delay path evaluated on the trigger cycle
  logic [QW-1:0]       diff_s, delta_s, limit_s;
  logic                arm_ok_s;
  logic [PROD_W-1:0]   prod_s, shifted_s;
  logic [PERIOD_W-1:0] scaled_s, sub_s, dly_s, dwell_ext_s, start_s;
  logic                short_s, chg_s;

  ign_state_e          state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] dly_q, dly_d;
  logic [PERIOD_W-1:0] start_q, start_d;
  logic                short_q, short_d;
  logic                chg_q, chg_d;
  logic                pend_q, pend_d;
  logic                coil_q, coil_d;
  logic                spark_pulse_q, spark_pulse_d;
  logic                short_pulse_q, short_pulse_d;
  logic                busy_q, busy_d;

  // Angle to spark, arm window test, saturating delay and dwell start offset
  always_comb begin
    // Both operands are zero-extended, so a borrow shows up in the top bit
    diff_s = {1'b0, spark_angle} - {1'b0, eng_phase};
    if (diff_s[QW-1]) begin
      delta_s = diff_s + QW'(CYCLE_QUANTA);
    end else begin
      delta_s = diff_s;
    end
    limit_s  = {1'b0, next_tooth_width} + QW'(MARGIN);
    arm_ok_s = (delta_s != {QW{1'b0}}) && (delta_s <= limit_s);

    prod_s    = PROD_W'(tooth_period) * PROD_W'(delta_s);
    shifted_s = prod_s >> FRAC_SHIFT;
    if (shifted_s > PROD_W'(CNT_MAX)) begin
      scaled_s = CNT_MAX;
    end else begin
      scaled_s = shifted_s[PERIOD_W-1:0];
    end
    if (scaled_s > PERIOD_W'(LAT_COMP)) begin
      sub_s = scaled_s - PERIOD_W'(LAT_COMP);
    end else begin
      sub_s = CNT_ZERO;
    end
    // A spark can never land on the arm edge itself
    if (sub_s == CNT_ZERO) begin
      dly_s = CNT_ONE;
    end else begin
      dly_s = sub_s;
    end

    dwell_ext_s = PERIOD_W'(dwell_clks);
    if (dly_s > dwell_ext_s) begin
      start_s = dly_s - dwell_ext_s;
    end else begin
      start_s = CNT_ZERO;
    end
    short_s = (dly_s < dwell_ext_s);
    chg_s   = (dwell_ext_s != CNT_ZERO);
  end

  // Channel FSM: next state, event counter and next registered outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dly_d         = dly_q;
    start_d       = start_q;
    short_d       = short_q;
    chg_d         = chg_q;
    pend_d        = 1'b0;
    spark_pulse_d = 1'b0;
    short_pulse_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          // Event captured on the previous edge; counter runs from 1 so
          // that cnt_q equals (edges since trigger) - 1 when compared.
          if (!ch_enable) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else if (chg_q && (start_q == CNT_ZERO)) begin
            state_d = ST_DWELL;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_ONE;
          end
        end else if (trigger && ch_enable && arm_ok_s) begin
          pend_d  = 1'b1;
          dly_d   = dly_s;
          start_d = start_s;
          short_d = short_s;
          chg_d   = chg_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!ch_enable) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == dly_q) begin
          // Only reachable with zero dwell: spark without a charge window
          state_d       = ST_IDLE;
          cnt_d         = CNT_ZERO;
          spark_pulse_d = 1'b1;
          short_pulse_d = short_q;
        end else if (chg_q && (cnt_q == start_q)) begin
          state_d = ST_DWELL;
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DWELL: begin
        if (!ch_enable) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == dly_q) begin
          state_d       = ST_IDLE;
          cnt_d         = CNT_ZERO;
          spark_pulse_d = 1'b1;
          short_pulse_d = short_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    coil_d = (state_d == ST_DWELL);
    busy_d = (state_d != ST_IDLE);
  end

  // State, timing and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_ZERO;
      dly_q         <= CNT_ZERO;
      start_q       <= CNT_ZERO;
      short_q       <= 1'b0;
      chg_q         <= 1'b0;
      pend_q        <= 1'b0;
      coil_q        <= 1'b0;
      spark_pulse_q <= 1'b0;
      short_pulse_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dly_q         <= dly_d;
      start_q       <= start_d;
      short_q       <= short_d;
      chg_q         <= chg_d;
      pend_q        <= pend_d;
      coil_q        <= coil_d;
      spark_pulse_q <= spark_pulse_d;
      short_pulse_q <= short_pulse_d;
      busy_q        <= busy_d;
    end
  end

  assign coil_out    = coil_q;
  assign spark_pulse = spark_pulse_q;
  assign short_dwell = short_pulse_q;
  assign busy        = busy_q;

endmodule

// File: rtl/ign_sched_multi.sv
// ---------------------------------------------------------------------------
// ign_sched_multi
// N-channel ignition scheduler with per-channel dwell control. Crank
// decoder buses are shared; each channel schedules independently.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   trigger              one-cycle tooth edge pulse
//   eng_phase            engine phase at trigger, quanta
//   next_tooth_width     quanta until next tooth
//   tooth_period         clk cycles per 2^FRAC_SHIFT quanta
//   spark_angle          channel i at [i*PHASE_W +: PHASE_W]
//   dwell_clks           channel i at [i*DWELL_W +: DWELL_W]
//   ch_enable            per-channel enable
//   coil_out             per-channel coil drive
//   spark_pulse          per-channel spark pulse
//   short_dwell          per-channel short-dwell flag pulse
//   busy                 per-channel armed indication
// ---------------------------------------------------------------------------
module ign_sched_multi
  import ign_pkg::*;
#(
  parameter int NCH          = IGN_NCH,
  parameter int PHASE_W      = IGN_PHASE_W,
  parameter int CYCLE_QUANTA = IGN_CYCLE_QUANTA,
  parameter int PERIOD_W     = IGN_PERIOD_W,
  parameter int FRAC_SHIFT   = IGN_FRAC_SHIFT,
  parameter int MARGIN       = IGN_MARGIN,
  parameter int LAT_COMP     = IGN_LAT_COMP,
  parameter int DWELL_W      = IGN_DWELL_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   trigger,
  input  logic [PHASE_W-1:0]     eng_phase,
  input  logic [PHASE_W-1:0]     next_tooth_width,
  input  logic [PERIOD_W-1:0]    tooth_period,
  input  logic [NCH*PHASE_W-1:0] spark_angle,
  input  logic [NCH*DWELL_W-1:0] dwell_clks,
  input  logic [NCH-1:0]         ch_enable,
  output logic [NCH-1:0]         coil_out,
  output logic [NCH-1:0]         spark_pulse,
  output logic [NCH-1:0]         short_dwell,
  output logic [NCH-1:0]         busy
);

  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      ign_sched_channel #(
        .PHASE_W      (PHASE_W),
        .CYCLE_QUANTA (CYCLE_QUANTA),
        .PERIOD_W     (PERIOD_W),
        .FRAC_SHIFT   (FRAC_SHIFT),
        .MARGIN       (MARGIN),
        .LAT_COMP     (LAT_COMP),
        .DWELL_W      (DWELL_W)
      ) u_ch (
        .clk              (clk),
        .reset_n          (reset_n),
        .trigger          (trigger),
        .eng_phase        (eng_phase),
        .next_tooth_width (next_tooth_width),
        .tooth_period     (tooth_period),
        .spark_angle      (spark_angle[i*PHASE_W +: PHASE_W]),
        .dwell_clks       (dwell_clks[i*DWELL_W +: DWELL_W]),
        .ch_enable        (ch_enable[i]),
        .coil_out         (coil_out[i]),
        .spark_pulse      (spark_pulse[i]),
        .short_dwell      (short_dwell[i]),
        .busy             (busy[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_ign_sched_multi.sv
// ---------------------------------------------------------------------------
// tb_ign_sched_multi
// Self-checking bench for ign_sched_multi: directed vector table, random
// events against a formula-level reference model, and hand-written
// sequences for multi-channel, abort, reset, saturation and re-arm cases.
// Edge numbering: E0 is the posedge that samples trigger; outputs are
// sampled 1 time unit after each later posedge E0+k.
// ---------------------------------------------------------------------------
module tb_ign_sched_multi;

  localparam int NCH = 4;
  localparam longint CQ = 15360;
  localparam longint MARGIN = 20;
  localparam longint LAT = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trigger;
  logic [15:0] eng_phase;
  logic [15:0] next_tooth_width;
  logic [31:0] tooth_period;
  logic [63:0] spark_angle;
  logic [95:0] dwell_clks;
  logic [3:0]  ch_enable;
  logic [3:0]  coil_out;
  logic [3:0]  spark_pulse;
  logic [3:0]  short_dwell;
  logic [3:0]  busy;

  int n_checks = 0;
  int n_err    = 0;

  ign_sched_multi dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .trigger          (trigger),
    .eng_phase        (eng_phase),
    .next_tooth_width (next_tooth_width),
    .tooth_period     (tooth_period),
    .spark_angle      (spark_angle),
    .dwell_clks       (dwell_clks),
    .ch_enable        (ch_enable),
    .coil_out         (coil_out),
    .spark_pulse      (spark_pulse),
    .short_dwell      (short_dwell),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     ch;
    longint tp, ph, ntw, ang, dwell;
    bit     arm;
    longint rise, spark;
    bit     shrt;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: edge offsets (relative to E0) straight from the timing rules
  function automatic void model(input longint tp, ph, ntw, ang, dwell,
                                output bit arm, output longint rise,
                                output longint spark, output bit shrt);
    longint q, sc, d, lim;
    q = ang - ph;
    if (q < 0) q = q + CQ;
    arm = (q != 0) && (q <= ntw + MARGIN);
    lim = (longint'(1) << 32) - 1;
    sc = (tp * q) / 256;
    if (sc > lim) sc = lim;
    d = sc - LAT;
    if (d < 1) d = 1;
    spark = arm ? 1 + d : -1;
    rise  = (arm && dwell != 0) ? 1 + ((d > dwell) ? d - dwell : 0) : -1;
    shrt  = arm && (d < dwell);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input longint tp, ph, ntw);
    eng_phase        = 16'(ph);
    next_tooth_width = 16'(ntw);
    tooth_period     = 32'(tp);
    trigger          = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  // Single-channel event: trigger, scramble inputs, then observe the channel
  task automatic run_event(input int ch, input longint tp, ph, ntw, ang, dwell,
                           input bit arm, input longint e_rise, e_spark,
                           input bit e_short, input string nm);
    int rise, spk, ncoil, nspark, nshort, limit;
    bit b1, bsp, csp, ssp;
    ch_enable = 4'b0000;
    ch_enable[ch] = 1'b1;
    spark_angle[ch*16 +: 16] = 16'(ang);
    dwell_clks[ch*24 +: 24]  = 24'(dwell);
    fire(tp, ph, ntw);
    // Later input changes must not disturb an armed event
    eng_phase        = 16'($urandom_range(0, 15359));
    next_tooth_width = 16'($urandom);
    tooth_period     = $urandom;
    spark_angle      = {$urandom, $urandom};
    dwell_clks       = {$urandom, $urandom, $urandom};
    limit = arm ? int'(e_spark) + 4 : 8;
    rise = -1; spk = -1; ncoil = 0; nspark = 0; nshort = 0;
    b1 = 1'b0; bsp = 1'b0; csp = 1'b0; ssp = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (k == 1) b1 = busy[ch];
      if (coil_out[ch]) begin
        ncoil++;
        if (rise < 0) rise = k;
      end
      if (short_dwell[ch]) nshort++;
      if (spark_pulse[ch]) begin
        nspark++;
        if (spk < 0) begin
          spk = k; bsp = busy[ch]; csp = coil_out[ch]; ssp = short_dwell[ch];
        end
      end
    end
    chk({nm, "/busy_E0+1"}, b1, arm);
    chk({nm, "/rise_edge"}, rise, e_rise);
    chk({nm, "/spark_edge"}, spk, e_spark);
    chk({nm, "/spark_count"}, nspark, arm ? 1 : 0);
    chk({nm, "/short_count"}, nshort, e_short ? 1 : 0);
    chk({nm, "/dwell_cycles"}, ncoil, (e_rise < 0) ? 0 : e_spark - e_rise);
    if (arm) begin
      chk({nm, "/busy_at_spark"}, bsp, 0);
      chk({nm, "/coil_at_spark"}, csp, 0);
      chk({nm, "/short_at_spark"}, ssp, e_short);
    end
    chk({nm, "/busy_after"}, busy[ch], 0);
    ch_enable = 4'b0000;
  endtask

  initial begin : main
    bit     m_arm[4], m_sh[4], ra;
    longint m_rise[4], m_spk[4], rr, rs;
    bit     rsh;
    longint angs[4], dws[4];
    int     f_rise[4], f_spk[4], n_spk[4], nb3, ncoil, nspk, nsh, got;

    vecs[0]  = '{0, 1000, 0,     600, 512, 500, 1'b1, 1495, 1995, 1'b0};
    vecs[1]  = '{1, 1000, 15300, 100, 100, 50,  1'b0, -1,   -1,   1'b0};
    vecs[2]  = '{1, 1000, 15300, 150, 100, 50,  1'b1, 570,  620,  1'b0};
    vecs[3]  = '{2, 256,  0,     100, 10,  100, 1'b1, 1,    5,    1'b1};
    vecs[4]  = '{3, 256,  300,   100, 300, 10,  1'b0, -1,   -1,   1'b0};
    vecs[5]  = '{0, 1,    0,     10,  1,   0,   1'b1, -1,   2,    1'b0};
    vecs[6]  = '{1, 256,  0,     100, 20,  0,   1'b1, -1,   15,   1'b0};
    vecs[7]  = '{2, 256,  0,     100, 120, 10,  1'b1, 105,  115,  1'b0};
    vecs[8]  = '{3, 256,  0,     100, 121, 10,  1'b0, -1,   -1,   1'b0};
    vecs[9]  = '{0, 256,  0,     100, 30,  24,  1'b1, 1,    25,   1'b0};
    vecs[10] = '{1, 1792, 15359, 10,  0,   5,   1'b1, 1,    2,    1'b1};

    reset_n = 1'b0; trigger = 1'b0; eng_phase = 16'd0; next_tooth_width = 16'd0;
    tooth_period = 32'd0; spark_angle = 64'd0; dwell_clks = 96'd0; ch_enable = 4'b0000;
    repeat (3) tick();
    chk("reset/coil_out", coil_out, 0);
    chk("reset/spark_pulse", spark_pulse, 0);
    chk("reset/short_dwell", short_dwell, 0);
    chk("reset/busy", busy, 0);
    reset_n = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 11; i++) begin
      run_event(vecs[i].ch, vecs[i].tp, vecs[i].ph, vecs[i].ntw, vecs[i].ang,
                vecs[i].dwell, vecs[i].arm, vecs[i].rise, vecs[i].spark,
                vecs[i].shrt, $sformatf("vec%0d", i));
    end

    // Random events against the reference model
    for (int i = 0; i < 24; i++) begin
      int ch;
      longint tp, ph, ntw, ang, dw;
      ch  = $urandom_range(0, 3);
      tp  = $urandom_range(1, 600);
      ph  = $urandom_range(0, 15359);
      ntw = $urandom_range(0, 300);
      ang = (ph + $urandom_range(0, int'(ntw) + 40)) % CQ;
      dw  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 800);
      model(tp, ph, ntw, ang, dw, ra, rr, rs, rsh);
      run_event(ch, tp, ph, ntw, ang, dw, ra, rr, rs, rsh, $sformatf("rnd%0d", i));
    end

    // Multi-channel: one trigger, independent timing, retrigger ignored
    angs = '{50, 80, 110, 400};
    dws  = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) begin
      spark_angle[i*16 +: 16] = 16'(angs[i]);
      dwell_clks[i*24 +: 24]  = 24'(dws[i]);
      model(256, 0, 200, angs[i], dws[i], m_arm[i], m_rise[i], m_spk[i], m_sh[i]);
      f_rise[i] = -1; f_spk[i] = -1; n_spk[i] = 0;
    end
    nb3 = 0;
    ch_enable = 4'b1111;
    fire(256, 0, 200);
    for (int k = 1; k <= 115; k++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (coil_out[i] && f_rise[i] < 0) f_rise[i] = k;
        if (spark_pulse[i]) begin
          n_spk[i]++;
          if (f_spk[i] < 0) f_spk[i] = k;
        end
      end
      if (busy[3]) nb3++;
      trigger = (k == 9);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("multi%0d/rise_edge", i), f_rise[i], m_rise[i]);
      chk($sformatf("multi%0d/spark_edge", i), f_spk[i], m_spk[i]);
      chk($sformatf("multi%0d/spark_count", i), n_spk[i], m_arm[i] ? 1 : 0);
    end
    chk("multi3/busy_cycles", nb3, 0);

    // Abort channel 1 during DWELL
    ch_enable = 4'b0010;
    spark_angle[16 +: 16] = 16'd80;
    dwell_clks[24 +: 24]  = 24'd40;
    nspk = 0; nsh = 0;
    fire(256, 0, 200);
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (spark_pulse[1]) nspk++;
      if (short_dwell[1]) nsh++;
      if (k == 40) begin
        chk("abort/coil_before", coil_out[1], 1);
        ch_enable[1] = 1'b0;
      end
      if (k == 41) begin
        chk("abort/coil_after", coil_out[1], 0);
        chk("abort/busy_after", busy[1], 0);
      end
    end
    chk("abort/spark_count", nspk, 0);
    chk("abort/short_count", nsh, 0);

    // Reset with ch0 in WAIT and ch2 in DWELL
    ch_enable = 4'b0101;
    spark_angle[0 +: 16]  = 16'd80;
    dwell_clks[0 +: 24]   = 24'd10;
    spark_angle[32 +: 16] = 16'd110;
    dwell_clks[48 +: 24]  = 24'd100;
    fire(256, 0, 200);
    repeat (20) tick();
    chk("rst/ch0_busy_before", busy[0], 1);
    chk("rst/ch2_coil_before", coil_out[2], 1);
    reset_n = 1'b0;
    tick();
    chk("rst/coil_out", coil_out, 0);
    chk("rst/busy", busy, 0);
    chk("rst/spark_pulse", spark_pulse, 0);
    reset_n = 1'b1;
    nspk = 0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (spark_pulse != 4'b0000) nspk++;
    end
    chk("rst/no_spark_after", nspk, 0);
    model(256, 0, 100, 10, 100, ra, rr, rs, rsh);
    run_event(0, 256, 0, 100, 10, 100, ra, rr, rs, rsh, "rst/rearm");

    // Saturating delay: stays armed, no charge, no spark
    ch_enable = 4'b1000;
    spark_angle[48 +: 16] = 16'd15000;
    dwell_clks[72 +: 24]  = 24'd1000;
    fire(64'hFFFF_FFFF, 0, 15000);
    got = 0; ncoil = 0; nspk = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (busy[3]) got++;
      if (coil_out[3]) ncoil++;
      if (spark_pulse[3]) nspk++;
    end
    chk("sat/busy_cycles", got, 60);
    chk("sat/coil_cycles", ncoil, 0);
    chk("sat/spark_count", nspk, 0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    ch_enable = 4'b0000;
    tick();

    // Re-arm on a trigger during the spark_pulse cycle
    ch_enable = 4'b0001;
    spark_angle[0 +: 16] = 16'd10;
    dwell_clks[0 +: 24]  = 24'd0;
    fire(256, 0, 100);
    got = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (spark_pulse[0]) begin
        got = k;
        break;
      end
    end
    chk("rearm/first_spark_edge", got, 5);
    spark_angle[0 +: 16] = 16'd20;
    fire(256, 0, 100);
    got = -1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 1) chk("rearm/busy_E0+1", busy[0], 1);
      if (spark_pulse[0] && got < 0) got = k;
    end
    chk("rearm/second_spark_edge", got, 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
